// File: rtl/serial_adder_if.sv
// Operand/result bus of the bit-serial adder.
// Handshake: the master raises start with a, b and cin valid; the slave
// accepts it only while busy is low (start is ignored otherwise, never
// queued). busy stays high from the accepting edge until the done pulse
// ends; sum/cout are valid while done is high and hold until the next
// accepted start.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one bit pair per cycle,
// LSB first, and the sum bits shift into the result register from the MSB.
// An operation takes WIDTH shift cycles plus one done cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_if.slave        bus,
    output logic [1:0]           fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             s_bit;
    logic             c_next;

    // Single full-adder cell working on the current LSBs of the operand registers.
    always_comb begin
        s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
        c_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Operands are captured here so later input changes cannot leak in.
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
                    carry  <= c_next;
                    cnt    <= cnt + CW'(1);
                    // Last bit pair: the carry leaving it is the final carry-out.
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout_r <= c_next;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_sr;
    assign bus.cout  = cout_r;
    assign fsm_state = state;

endmodule
